// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Register x0 is hardwired to zero and can never carry a dependency.
  localparam int unsigned REG_ZERO = 0;

  // Instruction word that IF/ID loads when it is flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next value: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory-wait freeze, load-use stall and
// taken-branch flush, resolved in that priority, plus stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              IF_stall,
  output logic              IF_flush,
  output logic              ID_EX_bubble,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e state_q, state_d;
  logic   load_use;
  logic   branch_flush;

  // A load in EX feeding a source read in ID; x0 never creates a dependency.
  always_comb begin
    load_use = id_valid && ex_memread && (ex_rd != REG_AW'(REG_ZERO)) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    branch_flush = id_valid && id_branch_taken;
  end

  // Control outputs and next state; a stall always suppresses a flush, so
  // IF_stall and IF_flush are mutually exclusive on every path.
  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    IF_stall     = 1'b0;
    IF_flush     = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      // Reset drives a NOP into IF/ID and a bubble into ID/EX.
      state_d      = RUN;
      pc_write     = 1'b0;
      IF_flush     = 1'b1;
      ID_EX_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            // Multi-cycle access: freeze everything until memory answers.
            state_d     = MEM_WAIT;
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            IF_stall    = 1'b1;
          end else if (load_use) begin
            // One-cycle stall; the load moves on to MEM and can forward.
            pc_write     = 1'b0;
            IF_stall     = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (branch_flush) begin
            IF_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Hazard and branch inputs are stale while frozen; ignore them.
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          IF_stall    = 1'b1;
          if (mem_ready) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register; reset aborts any outstanding memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (!pc_write),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (IF_flush),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second 4-bit-counter instance shares
// the stimulus to exercise counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs2, ex_memread, id_branch_taken;
  logic        mem_req, mem_ready;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        pc_write, IF_stall, IF_flush, ID_EX_bubble, pipe_freeze;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_write4, IF_stall4, IF_flush4, ID_EX_bubble4, pipe_freeze4;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic [4:0]  ctl;

  int passed = 0;
  int total  = 0;

  // ctl = {pc_write, IF_stall, IF_flush, ID_EX_bubble, pipe_freeze}
  localparam logic [4:0] C_RESET  = 5'b00110;
  localparam logic [4:0] C_RUN    = 5'b10000;
  localparam logic [4:0] C_STALL  = 5'b01010;
  localparam logic [4:0] C_FLUSH  = 5'b10100;
  localparam logic [4:0] C_FREEZE = 5'b01001;

  always #5 clk = ~clk;

  assign ctl = {pc_write, IF_stall, IF_flush, ID_EX_bubble, pipe_freeze};

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .id_branch_taken(id_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .IF_stall(IF_stall),
    .IF_flush(IF_flush), .ID_EX_bubble(ID_EX_bubble),
    .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .id_branch_taken(id_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write4), .IF_stall(IF_stall4),
    .IF_flush(IF_flush4), .ID_EX_bubble(ID_EX_bubble4),
    .pipe_freeze(pipe_freeze4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic idle();
    id_valid = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
    id_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    total++;
    if (ctl !== C_RESET) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET);
    else passed++;
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd3;
    #1;
    total++;
    if (ctl !== C_STALL) $display("FAIL load_use_ctl got=%b exp=%b", ctl, C_STALL);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (stall_cnt !== 32'd1) $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    else passed++;
    // rs2 matches but is not read: no hazard
    @(negedge clk);
    id_rs1 = 5'd4; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL rs2_unused_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
    // matching rs1 but ID bubble: no hazard
    @(negedge clk);
    id_valid = 1'b0; id_rs1 = 5'd5;
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL id_invalid_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle();
    id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL x0_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (stall_cnt !== 32'd1) $display("FAIL x0_cnt got=%0d exp=1", stall_cnt);
    else passed++;
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle();
    id_valid = 1'b1; id_branch_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_FLUSH) $display("FAIL branch_ctl got=%b exp=%b", ctl, C_FLUSH);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (flush_cnt !== 32'd1) $display("FAIL branch_cnt got=%0d exp=1", flush_cnt);
    else passed++;
  endtask

  task automatic test_stall_over_branch();
    @(negedge clk);
    idle();
    id_valid = 1'b1; id_branch_taken = 1'b1; ex_memread = 1'b1;
    ex_rd = 5'd7; id_rs1 = 5'd2; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1;
    total++;
    if (ctl !== C_STALL) $display("FAIL stall_over_branch_ctl got=%b exp=%b", ctl, C_STALL);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2)
      $display("FAIL stall_over_branch_cnt got=%0d/%0d exp=1/2", flush_cnt, stall_cnt);
    else passed++;
    @(negedge clk);
    ex_memread = 1'b0;
    #1;
    total++;
    if (ctl !== C_FLUSH) $display("FAIL branch_retry_ctl got=%b exp=%b", ctl, C_FLUSH);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (flush_cnt !== 32'd2) $display("FAIL branch_retry_cnt got=%0d exp=2", flush_cnt);
    else passed++;
  endtask

  task automatic test_single_cycle_mem();
    @(negedge clk);
    idle();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL mem_single_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
    @(negedge clk);
    idle();
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL mem_single_after_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      mem_req   = (i < 4);
      mem_ready = (i == 4);
      // stale branch and hazard inputs must be ignored while frozen
      if (i == 2) begin
        id_valid = 1'b1; id_branch_taken = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
      end
      #1;
      total++;
      if (ctl !== C_FREEZE) $display("FAIL mem_wait_ctl[%0d] got=%b exp=%b", i, ctl, C_FREEZE);
      else passed++;
    end
    @(negedge clk);
    idle();
    id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    #1;
    total++;
    if (ctl !== C_STALL) $display("FAIL mem_return_ctl got=%b exp=%b", ctl, C_STALL);
    else passed++;
    total++;
    if (stall_cnt !== 32'd5) $display("FAIL mem_wait_cnt got=%0d exp=5", stall_cnt);
    else passed++;
    @(negedge clk);
    idle();
    #1;
    total++;
    if (ctl !== C_RUN || stall_cnt !== 32'd6)
      $display("FAIL mem_after_ctl got=%b/%0d exp=%b/6", ctl, stall_cnt, C_RUN);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    idle();
    mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ctl !== C_RESET) $display("FAIL reset_mid_ctl got=%b exp=%b", ctl, C_RESET);
    else passed++;
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL reset_mid_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    else passed++;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN) $display("FAIL reset_mid_release_ctl got=%b exp=%b", ctl, C_RUN);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    mem_req = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1;
    total++;
    if (stall_cnt4 !== 4'd15) $display("FAIL sat_cnt4 got=%0d exp=15", stall_cnt4);
    else passed++;
    total++;
    if (stall_cnt !== 32'd20) $display("FAIL sat_cnt32 got=%0d exp=20", stall_cnt);
    else passed++;
    @(negedge clk);
    mem_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    idle();
    #1;
    total++;
    if (ctl !== C_RUN || stall_cnt4 !== 4'd15)
      $display("FAIL sat_exit got=%b/%0d exp=%b/15", ctl, stall_cnt4, C_RUN);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_stall_over_branch();
    test_single_cycle_mem();
    test_mem_wait();
    test_reset_mid_wait();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core.
- Generates pc_write, IF_stall and IF_flush for the IF/ID pipeline register, a bubble for ID/EX, and a global freeze for data-memory waits.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses with a fixed priority.
- Keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_AW  ID source register 1
id_rs2  input  REG_AW  ID source register 2
id_uses_rs2  input  1  ID instruction reads rs2
ex_memread  input  1  EX stage instruction is a load
ex_rd  input  REG_AW  EX stage destination register
id_branch_taken  input  1  branch resolved taken in ID
mem_req  input  1  MEM stage starts a data-memory access this cycle
mem_ready  input  1  data memory completes the access
pc_write  output  1  PC register may update
IF_stall  output  1  IF/ID holds its contents
IF_flush  output  1  IF/ID loads a NOP (all zeros)
ID_EX_bubble  output  1  ID/EX loads control-zero bubble
pipe_freeze  output  1  all pipeline registers hold
stall_cnt  output  CNT_W  cycles with pc_write=0 since reset
flush_cnt  output  CNT_W  cycles with IF_flush=1 since reset

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN; stall_cnt=0; flush_cnt=0.
  - Outputs forced: pc_write=0, IF_stall=0, IF_flush=1, ID_EX_bubble=1, pipe_freeze=0.
  - Reset mid-MEM_WAIT aborts the wait immediately.
- FSM states RUN and MEM_WAIT; state is registered, control outputs are combinational from state and inputs.
- RUN, evaluated in priority order:
  1. Memory wait: mem_req=1 and mem_ready=0.
     - pipe_freeze=1, pc_write=0, IF_stall=1, IF_flush=0, ID_EX_bubble=0.
     - Next state MEM_WAIT.
     - mem_req=1 with mem_ready=1 in the same cycle is a single-cycle access: no freeze, stay RUN.
  2. Load-use hazard: id_valid and ex_memread and ex_rd!=0 and (ex_rd==id_rs1, or id_uses_rs2 and ex_rd==id_rs2).
     - pc_write=0, IF_stall=1, ID_EX_bubble=1, IF_flush=0.
     - Lasts exactly one cycle: the load advances to MEM.
  3. Branch flush: id_valid and id_branch_taken.
     - IF_flush=1, pc_write=1, IF_stall=0, ID_EX_bubble=0.
  4. Otherwise: pc_write=1, all other controls 0.
- Simultaneous load-use and taken branch: the stall wins and the flush is suppressed. The branch is re-resolved next cycle with forwarded data.
- Register x0 (index 0) never causes a hazard.
- MEM_WAIT:
  - pipe_freeze=1, pc_write=0, IF_stall=1, IF_flush=0, ID_EX_bubble=0. All hazard/branch inputs are ignored.
  - mem_ready=1 returns to RUN the following cycle.
  - In that return cycle, hazards are evaluated normally from the current inputs.
- IF_stall and IF_flush are never both 1.
- Counters:
  - stall_cnt increments on every cycle with pc_write=0 (excluding reset).
  - flush_cnt increments on every cycle with IF_flush=1 (excluding reset).
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (RUN, MEM_WAIT);
  - constant REG_ZERO=0;
  - NOP encoding 32'h0000_0000 used by IF/ID on flush.
- One natural sub-module: sat_counter (CNT_W-bit saturating incrementer), instantiated twice.

Test Plan:
- Reset, then id_valid=1, ex_memread=1, ex_rd=5, id_rs1=5 for one cycle -> pc_write=0, IF_stall=1, ID_EX_bubble=1; stall_cnt=1 next cycle.
- ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, pc_write=1; stall_cnt unchanged.
- id_branch_taken=1 with no hazard -> IF_flush=1, pc_write=1; flush_cnt 0->1.
- Load-use on rs2 (id_uses_rs2=1) plus id_branch_taken=1 in the same cycle -> IF_stall=1, IF_flush=0, flush_cnt unchanged. Next cycle (no hazard) -> IF_flush=1.
- mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> pipe_freeze=1 for 5 cycles, back to RUN, stall_cnt=5.
- rst_n pulsed low during MEM_WAIT -> outputs immediately at reset values, counters 0, RUN after release.
- Force stall_cnt near saturation (CNT_W=4 build), apply 20 stall cycles -> stall_cnt holds at 15.
